ahb_sram_backend: RTL and testbench

//   Word-organised synchronous-write / asynchronous-read SRAM backend fed by the AHB slave adapter's

---
 rtl/ahb_sram_backend.sv | 150 +++++++++++++++
 tb/tb_ahb_sram_backend.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_backend.sv
// Word-organised SRAM backend behind the AHB slave adapter: post-reset clear, programmable
// wait states, same-cycle write-to-read forwarding and a sticky out-of-range flag.
module ahb_sram_backend #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH       = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0,
    parameter int                    INIT_ZERO   = 1
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    input  logic                    re,
    input  logic [DATA_WIDTH/8-1:0] rsel,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic                    we,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wsel,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    slave_rdy,
    output logic                    init_done,
    output logic                    oor_err
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int SHIFT = (LANES > 1) ? $clog2(LANES) : 0;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [3:0]            WAIT_CNT = 4'(WAIT_STATES);
    localparam bit                    HAS_WAIT = (WAIT_STATES > 0);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_READY = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam state_t RESET_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_READY;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   init_idx_q, init_idx_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               oor_q, oor_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Address decode: word index relative to BASE_ADDR, range checked on the full index.
    logic [ADDR_WIDTH-1:0] r_word, w_word;
    logic                  r_in, w_in;
    logic [IDX_W-1:0]      r_idx, w_idx;

    assign r_word = (raddr - BASE_ADDR) >> SHIFT;
    assign w_word = (waddr - BASE_ADDR) >> SHIFT;
    assign r_in   = (raddr >= BASE_ADDR) && (r_word < DEPTH_A);
    assign w_in   = (waddr >= BASE_ADDR) && (w_word < DEPTH_A);
    assign r_idx  = r_word[IDX_W-1:0];
    assign w_idx  = w_word[IDX_W-1:0];

    logic is_ready, commit, wr_en, fwd;

    assign is_ready = (state_q == ST_READY);
    assign commit   = is_ready && (re || we);
    assign wr_en    = is_ready && we && w_in;
    assign fwd      = we && w_in && (w_idx == r_idx);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= RESET_STATE;
            init_idx_q <= '0;
            cnt_q      <= '0;
            oor_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            cnt_q      <= cnt_d;
            oor_q      <= oor_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        cnt_d      = cnt_q;
        oor_d      = oor_q;
        case (state_q)
            ST_INIT: begin
                init_idx_d = init_idx_q + 1'b1;
                if (init_idx_q == LAST_IDX) begin
                    state_d    = ST_READY;
                    init_idx_d = '0;
                end
            end
            ST_READY: begin
                if (commit) begin
                    // Out-of-range accesses are flagged but still pay the wait states.
                    if ((re && !r_in) || (we && !w_in)) begin
                        oor_d = 1'b1;
                    end
                    if (HAS_WAIT) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_CNT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    // The array has no reset: contents survive a reset unless the INIT sweep clears them.
    always_ff @(posedge HCLK) begin
        if (state_q == ST_INIT) begin
            mem[init_idx_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (wsel[i]) begin
                    mem[w_idx][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    logic [DATA_WIDTH-1:0] rd_word;

    always_comb begin
        rd_word = mem[r_idx];
        rdata   = '0;
        if (is_ready && re && r_in) begin
            for (int i = 0; i < LANES; i++) begin
                if (rsel[i]) begin
                    rdata[i*8 +: 8] = (fwd && wsel[i]) ? wdata[i*8 +: 8] : rd_word[i*8 +: 8];
                end
            end
        end
    end

    assign slave_rdy = is_ready;
    assign init_done = (state_q != ST_INIT);
    assign oor_err   = oor_q;

endmodule

// File: tb/tb_ahb_sram_backend.sv
// Directed bench for ahb_sram_backend: one instance without wait states, one with two.
module tb_ahb_sram_backend;

    logic        HCLK;
    logic        HRESETn;
    logic [31:0] raddr, waddr, wdata;
    logic        re, we;
    logic [3:0]  rsel, wsel;

    logic [31:0] rdata0, rdata1;
    logic        rdy0, rdy1, done0, done1, oor0, oor1;

    int n_checks = 0;
    int n_errors = 0;

    ahb_sram_backend #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .BASE_ADDR(32'h0),
        .WAIT_STATES(0), .INIT_ZERO(1)
    ) dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .raddr(raddr), .re(re), .rsel(rsel),
        .waddr(waddr), .we(we), .wdata(wdata), .wsel(wsel),
        .rdata(rdata0), .slave_rdy(rdy0), .init_done(done0), .oor_err(oor0)
    );

    ahb_sram_backend #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .BASE_ADDR(32'h0),
        .WAIT_STATES(2), .INIT_ZERO(1)
    ) dut1 (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .raddr(raddr), .re(re), .rsel(rsel),
        .waddr(waddr), .we(we), .wdata(wdata), .wsel(wsel),
        .rdata(rdata1), .slave_rdy(rdy1), .init_done(done1), .oor_err(oor1)
    );

    // Clock / reset
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drivers
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_rd(input logic r, input logic [31:0] a, input logic [3:0] s);
        re    = r;
        raddr = a;
        rsel  = s;
    endtask

    task automatic drive_wr(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        we    = w;
        waddr = a;
        wdata = d;
        wsel  = s;
    endtask

    task automatic settle();
        #1;
    endtask

    // Release reset and count edges until slave_rdy rises on dut0 (bounded).
    task automatic release_and_count(input string tag);
        int cyc;
        cyc = 0;
        HRESETn = 1'b1;
        while (!rdy0 && cyc < 40) begin
            step();
            cyc++;
        end
        check_eq(tag, 32'(cyc), 32'd16);
        check_eq({tag, "_rdy1"}, {31'd0, rdy1}, 32'd1);
        check_eq({tag, "_done"}, {31'd0, done0}, 32'd1);
    endtask

    initial begin
        HRESETn = 1'b0;
        drive_rd(1'b1, 32'h0, 4'hF);
        drive_wr(1'b0, 32'h0, 32'h0, 4'h0);
        #2;

        // 1: reset values, init latency, cleared array
        check_eq("rst_rdy0",  {31'd0, rdy0},  32'd0);
        check_eq("rst_done0", {31'd0, done0}, 32'd0);
        check_eq("rst_oor0",  {31'd0, oor0},  32'd0);
        check_eq("rst_rdata", rdata0, 32'h0);
        check_eq("rst_rdy1",  {31'd0, rdy1},  32'd0);
        step();
        release_and_count("init_cycles");
        drive_rd(1'b1, 32'h1C, 4'hF);
        settle();
        check_eq("init_word7", rdata0, 32'h0);

        // 2: full write then single-lane merge
        drive_rd(1'b0, 32'h0, 4'h0);
        drive_wr(1'b1, 32'h4, 32'hDEADBEEF, 4'hF);
        step();
        drive_wr(1'b1, 32'h4, 32'h0000AA00, 4'h2);
        step();
        drive_wr(1'b0, 32'h0, 32'h0, 4'h0);
        drive_rd(1'b1, 32'h4, 4'hF);
        settle();
        check_eq("lane_merge", rdata0, 32'hDEADAAEF);
        drive_rd(1'b1, 32'h4, 4'h5);
        settle();
        check_eq("rsel_mask", rdata0, 32'h00AD00EF);
        drive_rd(1'b0, 32'h4, 4'hF);
        settle();
        check_eq("re_low_zero", rdata0, 32'h0);

        // 3: same-cycle forwarding on a zeroed word
        drive_wr(1'b1, 32'h8, 32'h11223344, 4'h3);
        drive_rd(1'b1, 32'h8, 4'hF);
        settle();
        check_eq("raw_fwd", rdata0, 32'h00003344);
        step();
        drive_wr(1'b0, 32'h0, 32'h0, 4'h0);
        settle();
        check_eq("raw_stored", rdata0, 32'h00003344);

        // 5: out-of-range write
        drive_rd(1'b0, 32'h0, 4'h0);
        drive_wr(1'b1, 32'h0, 32'h12345678, 4'hF);
        step();
        drive_wr(1'b1, 32'h40, 32'hFFFFFFFF, 4'hF);
        settle();
        check_eq("oor_before", {31'd0, oor0}, 32'd0);
        step();
        drive_wr(1'b0, 32'h0, 32'h0, 4'h0);
        settle();
        check_eq("oor_set", {31'd0, oor0}, 32'd1);
        drive_rd(1'b1, 32'h40, 4'hF);
        settle();
        check_eq("oor_read", rdata0, 32'h0);
        drive_rd(1'b1, 32'h0, 4'hF);
        settle();
        check_eq("oor_word0", rdata0, 32'h12345678);
        drive_rd(1'b0, 32'h0, 4'h0);
        step(); step(); step();
        check_eq("oor_sticky", {31'd0, oor0}, 32'd1);

        // 4: two wait states on dut1; writes during WAIT dropped
        step(); step();
        check_eq("ws_idle_rdy", {31'd0, rdy1}, 32'd1);
        drive_wr(1'b1, 32'h0, 32'hA5A5A5A5, 4'hF);
        step();
        drive_wr(1'b1, 32'h0, 32'h00000000, 4'hF);
        drive_rd(1'b1, 32'h0, 4'hF);
        settle();
        check_eq("ws_low1", {31'd0, rdy1}, 32'd0);
        check_eq("ws_rdata0", rdata1, 32'h0);
        step();
        check_eq("ws_low2", {31'd0, rdy1}, 32'd0);
        drive_wr(1'b0, 32'h0, 32'h0, 4'h0);
        step();
        check_eq("ws_back", {31'd0, rdy1}, 32'd1);
        check_eq("ws_kept", rdata1, 32'hA5A5A5A5);
        drive_rd(1'b0, 32'h0, 4'h0);

        // 6: reset during INIT restarts the sweep
        HRESETn = 1'b0;
        settle();
        check_eq("rst2_oor", {31'd0, oor0}, 32'd0);
        step();
        HRESETn = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check_eq("mid_init_rdy", {31'd0, rdy0}, 32'd0);
        HRESETn = 1'b0;
        settle();
        check_eq("mid_rst_done", {31'd0, done0}, 32'd0);
        step();
        release_and_count("reinit_cycles");
        drive_rd(1'b1, 32'h4, 4'hF);
        settle();
        check_eq("reinit_word1", rdata0, 32'h0);
        drive_rd(1'b1, 32'h8, 4'hF);
        settle();
        check_eq("reinit_word2", rdata0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
